pinmux_pad_attr_sequencer: RTL and testbench
============================================

// Module: pinmux_pad_attr_sequencer
// PURPOSE
//  Sequences pad-attribute reconfiguration for the pinmux. Software writes per-pad
//  attributes (pad type, pull, drive) into a shadow bank. A commit then applies every
//  dirty pad one at a time, isolating the pad before and after each change. attr_o
//  feeds the per-pad prim_pad_attr instances.
// PARAMETERS
//  NumPads      8             number of pads managed (>=1)
//  SettleCycles 4             isolation cycles before and after each apply (>=1, elab assert)
//  ResetAttr    '0            pad_attr_t value driven on attr_o and held in shadow at reset
// PORTS
//  clk_i          in   1                  clock
//  rst_ni         in   1                  reset, asynchronous, active-low
//  shadow_we_i    in   1                  shadow write strobe
//  shadow_idx_i   in   $clog2(NumPads)    pad index for write
//  shadow_attr_i  in   $bits(pad_attr_t)  attribute to write
//  commit_i       in   1                  start applying dirty pads (pulse)
//  busy_o         out  1                  sequencer not IDLE
//  done_o         out  1                  one-cycle pulse at end of a commit run
//  iso_o          out  NumPads            per-pad isolation, zero-or-one-hot
//  attr_o         out  NumPads x pad_attr_t  applied attributes (registered)
// BEHAVIOUR
//  Reset (async, rst_ni=0): attr_o=ResetAttr for all pads; shadow=ResetAttr; dirty=0;
//   iso_o=0; busy_o=0; done_o=0; state=IDLE; counter=0. Takes effect mid-sequence too.
//  Shadow write (any state): if shadow_we_i and idx<NumPads: shadow[idx]<=attr and
//   dirty[idx]<=1. idx>=NumPads is ignored. The dirty bit is set even if attr equals attr_o.
//  FSM (one transition per clk edge):
//   IDLE    : commit_i -> SCAN; otherwise stay. commit_i is ignored in all other states.
//   SCAN    : 1 cycle. cur<=lowest dirty index -> ISOLATE; no dirty bit set -> DONE.
//   ISOLATE : iso_o[cur]=1 for exactly SettleCycles cycles -> APPLY.
//   APPLY   : 1 cycle, iso_o[cur]=1. At exit edge: attr_o[cur]<=shadow[cur], clear dirty[cur].
//             A shadow write to cur in the same cycle wins: dirty stays 1 and the new value
//             is re-applied in a later pass.
//   SETTLE  : iso_o[cur]=1 for exactly SettleCycles cycles -> SCAN.
//   DONE    : 1 cycle, done_o=1 -> IDLE.
//  busy_o=1 in every state except IDLE. Per-pad cost: 2*SettleCycles+2 cycles.
//   A run over P dirty pads keeps busy_o high for P*(2S+2)+2 cycles.
//  Pads dirtied mid-run are processed in the same run, because each SCAN rescans.
//  Commit with no dirty pads: SCAN -> DONE, so busy_o is high for 2 cycles with done_o
//   in the second.
//  attr_o[i] changes only in APPLY with cur==i. iso_o is never multi-hot.
//  Settle counter: width $clog2(SettleCycles+1). Loaded on entry to ISOLATE/SETTLE,
//   decrements to 0, saturates at 0.
// STRUCTURE
//  prim_pad_wrapper_pkg: pad_type_e (existing).
//  pinmux_pkg: pad_attr_t packed {pad_type_e pad_type; logic pull_en; logic pull_sel;
//   logic [1:0] drive} and pad_seq_state_e {IDLE,SCAN,ISOLATE,APPLY,SETTLE,DONE}.
//  One sub-module: pinmux_settle_timer (load/decrement/expired counter), instantiated once.
//  Lowest-dirty search is a combinational priority encoder, kept inline.
// TESTING (NumPads=8, SettleCycles=4, ResetAttr='0)
//  1 Reset: drop rst_ni -> attr_o all 0, iso_o=0, busy_o=0, done_o=0, async (before clk).
//  2 Write pad3=5'b1_1_0_10, commit -> iso_o=8'h08 for 9 cycles; attr_o[3] updates after
//    the 5th iso cycle; done_o pulses on busy cycle 12; busy_o then drops.
//  3 Dirty pads 6 and 1, commit -> pad1 is isolated/applied before pad6; busy_o high 22
//    cycles; exactly one done_o.
//  4 Commit with no dirty pads -> busy_o high 2 cycles, done_o in the 2nd; attr_o unchanged.
//  5 Mid-run: write pad5 during pad1 SETTLE, and write pad1 in its APPLY cycle ->
//    pad1 and pad5 are processed again in the same run; final attr_o holds the last
//    written values. commit_i pulsed while busy has no effect.
//  6 Write idx=8 (OOR) ignored; rst_ni low during SETTLE of pad2 -> iso_o=0,
//    attr_o[2]=ResetAttr, dirty cleared; after release a commit yields the no-dirty run.

Source files
------------

// File: rtl/pinmux_pkg.sv
// Pinmux shared types: per-pad attribute word and pad-sequencer state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package pinmux_pkg;

  // Attribute word applied to one pad; pad_type sits in the MSB.
  typedef struct packed {
    prim_pad_wrapper_pkg::pad_type_e pad_type;
    logic                            pull_en;
    logic                            pull_sel;
    logic [1:0]                      drive;
  } pad_attr_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISOLATE,
    APPLY,
    SETTLE,
    DONE
  } pad_seq_state_e;

endpackage

// File: rtl/prim_pad_wrapper_pkg.sv
// Pad primitive types shared by the pad wrappers and the pinmux.
// Latency: n/a (types only).
// Backpressure: n/a.
package prim_pad_wrapper_pkg;

  // Electrical flavour of a pad cell.
  typedef enum logic {
    BidirStd = 1'b0,
    BidirOd  = 1'b1
  } pad_type_e;

endpackage

// File: rtl/pinmux_settle_timer.sv
// Settle timer: counts the isolation window before and after a pad attribute change.
// Latency: load sets the count to Cycles; lastCycle is high in the Cycles-th cycle after load.
// Backpressure: none; load may be asserted at any time and restarts the window.
module pinmux_settle_timer #(
  parameter int Cycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load,
  output logic lastCycle
);

  localparam int CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] cnt;

  // Load on window entry, otherwise count down and hold at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CntW'(Cycles);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A count of one means the current cycle closes the window.
  assign lastCycle = (cnt <= CntW'(1));

endmodule

// File: rtl/pinmux_pad_attr_sequencer.sv
// Pad-attribute sequencer: shadows per-pad attributes and applies dirty pads one at a time under isolation.
// Latency: each dirty pad costs 2*SettleCycles+2 cycles; a run adds one scan and one done cycle.
// Backpressure: none; commit is dropped while busy, shadow writes are accepted in every state.
module pinmux_pad_attr_sequencer
  import pinmux_pkg::*;
#(
  parameter int        NumPads      = 8,
  parameter int        SettleCycles = 4,
  parameter pad_attr_t ResetAttr    = '0,
  localparam int       IdxW         = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      shadow_we_i,
  input  logic [IdxW-1:0]           shadow_idx_i,
  input  pad_attr_t                 shadow_attr_i,
  input  logic                      commit_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [NumPads-1:0]        iso_o,
  output pad_attr_t [NumPads-1:0]   attr_o
);

  if (SettleCycles < 1) begin : gBadSettle
    $error("SettleCycles must be at least 1");
  end
  if (NumPads < 1) begin : gBadPads
    $error("NumPads must be at least 1");
  end

  pad_seq_state_e            state;
  pad_attr_t [NumPads-1:0]   shadow;
  logic [NumPads-1:0]        dirty;
  logic [IdxW-1:0]           cur;
  logic [IdxW-1:0]           lowIdx;
  logic                      anyDirty;
  logic                      idxOk;
  logic                      timerLoad;
  logic                      lastCycle;

  // Priority encoder: lowest-numbered dirty pad wins.
  always_comb begin
    anyDirty = |dirty;
    lowIdx   = '0;
    for (int i = NumPads - 1; i >= 0; i--) begin
      if (dirty[i]) lowIdx = IdxW'(i);
    end
  end

  assign idxOk     = (32'(shadow_idx_i) < NumPads);
  assign timerLoad = ((state == SCAN) && anyDirty) || (state == APPLY);

  pinmux_settle_timer #(
    .Cycles(SettleCycles)
  ) uSettleTimer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (timerLoad),
    .lastCycle(lastCycle)
  );

  // Shadow bank, dirty flags and applied attributes; a same-cycle write beats the apply-clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow <= {NumPads{ResetAttr}};
      attr_o <= {NumPads{ResetAttr}};
      dirty  <= '0;
    end else begin
      if (state == APPLY) begin
        attr_o[cur] <= shadow[cur];
        dirty[cur]  <= 1'b0;
      end
      if (shadow_we_i && idxOk) begin
        shadow[shadow_idx_i] <= shadow_attr_i;
        dirty[shadow_idx_i]  <= 1'b1;
      end
    end
  end

  // Sequencer FSM with registered busy/done/isolation outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cur    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      iso_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (commit_i) begin
            state  <= SCAN;
            busy_o <= 1'b1;
          end
        end
        SCAN: begin
          if (anyDirty) begin
            state <= ISOLATE;
            cur   <= lowIdx;
            iso_o <= NumPads'(1) << lowIdx;
          end else begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        ISOLATE: begin
          if (lastCycle) state <= APPLY;
        end
        APPLY: begin
          state <= SETTLE;
        end
        SETTLE: begin
          if (lastCycle) begin
            state <= SCAN;
            iso_o <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pinmux_pad_attr_sequencer.sv
// Bench for the pad-attribute sequencer: directed scenarios plus random traffic against a slot-timeline model.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: n/a.
module tb_pinmux_pad_attr_sequencer;
  import pinmux_pkg::*;

  localparam int NP = 8;
  localparam int S  = 4;

  logic                clk = 1'b0;
  logic                rst_ni = 1'b1;
  logic                shadow_we_i = 1'b0;
  logic [2:0]          shadow_idx_i = '0;
  pad_attr_t           shadow_attr_i = '0;
  logic                commit_i = 1'b0;
  logic                busy_o;
  logic                done_o;
  logic [NP-1:0]       iso_o;
  pad_attr_t [NP-1:0]  attr_o;

  pinmux_pad_attr_sequencer #(
    .NumPads     (NP),
    .SettleCycles(S),
    .ResetAttr   ('0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .shadow_we_i  (shadow_we_i),
    .shadow_idx_i (shadow_idx_i),
    .shadow_attr_i(shadow_attr_i),
    .commit_i     (commit_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .iso_o        (iso_o),
    .attr_o       (attr_o)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic chkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Reference model: a run is a chain of slots of 2S+2 cycles.
  // Slot position 0 is the scan, 1..S isolate, S+1 apply, S+2..2S+1 settle.
  pad_attr_t           mShadow [NP];
  pad_attr_t [NP-1:0]  mAttr;
  bit [NP-1:0]         mDirty;
  int                  mMode;   // 0 idle, 1 running, 2 done cycle
  int                  mPos;
  int                  mCur;

  int busyCnt, doneCnt, isoCnt, doneAt;
  logic [NP-1:0] firstIso;

  function automatic int lowestDirty(input bit [NP-1:0] d);
    for (int i = 0; i < NP; i++) if (d[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NP; i++) mShadow[i] = '0;
    mAttr  = '0;
    mDirty = '0;
    mMode  = 0;
    mPos   = 0;
    mCur   = 0;
  endtask

  task automatic modelStep();
    bit [NP-1:0] oldDirty = mDirty;
    int low;
    if (mMode == 1 && mPos == S + 1) begin
      mAttr[mCur]  = mShadow[mCur];
      mDirty[mCur] = 1'b0;
    end
    if (shadow_we_i) begin
      mShadow[shadow_idx_i] = shadow_attr_i;
      mDirty[shadow_idx_i]  = 1'b1;
    end
    case (mMode)
      0: if (commit_i) begin mMode = 1; mPos = 0; end
      1: begin
        if (mPos == 0) begin
          low = lowestDirty(oldDirty);
          if (low < 0) mMode = 2;
          else begin mCur = low; mPos = 1; end
        end else if (mPos == 2 * S + 1) mPos = 0;
        else mPos++;
      end
      default: mMode = 0;
    endcase
  endtask

  task automatic compareAll();
    logic [NP-1:0] expIso;
    expIso = (mMode == 1 && mPos >= 1) ? (8'h01 << mCur) : 8'h00;
    chkVal("busy", 64'(busy_o), 64'(mMode != 0));
    chkVal("done", 64'(done_o), 64'(mMode == 2));
    chkVal("iso", 64'(iso_o), 64'(expIso));
    chkVal("attr", 64'(attr_o), 64'(mAttr));
    chkVal("iso_onehot0", 64'($onehot0(iso_o)), 64'd1);
  endtask

  task automatic clearStats();
    busyCnt = 0; doneCnt = 0; isoCnt = 0; doneAt = 0; firstIso = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_ni) modelStep();
    @(negedge clk);
    compareAll();
    if (busy_o) busyCnt++;
    if (done_o) begin doneCnt++; doneAt = busyCnt; end
    if (iso_o != '0) begin
      isoCnt++;
      if (firstIso == '0) firstIso = iso_o;
    end
    shadow_we_i = 1'b0;
    commit_i    = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [4:0] val);
    shadow_we_i   = 1'b1;
    shadow_idx_i  = 3'(idx);
    shadow_attr_i = pad_attr_t'(val);
    tick();
  endtask

  task automatic commit();
    commit_i = 1'b1;
    tick();
  endtask

  task automatic runIdle(input string tag);
    for (int n = 0; n < 300 && busy_o; n++) tick();
    chkVal(tag, 64'(busy_o), 64'd0);
  endtask

  initial begin
    clearStats();
    modelReset();

    // Reset takes effect without a clock edge.
    #2 rst_ni = 1'b0;
    #1;
    chkVal("rst_busy", 64'(busy_o), 64'd0);
    chkVal("rst_done", 64'(done_o), 64'd0);
    chkVal("rst_iso", 64'(iso_o), 64'd0);
    chkVal("rst_attr", 64'(attr_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Single pad.
    wr(3, 5'b1_1_0_10);
    clearStats();
    commit();
    runIdle("t2_timeout");
    chkVal("t2_busy_len", 64'(busyCnt), 64'd12);
    chkVal("t2_iso_len", 64'(isoCnt), 64'd9);
    chkVal("t2_done_cnt", 64'(doneCnt), 64'd1);
    chkVal("t2_done_at", 64'(doneAt), 64'd12);
    chkVal("t2_attr3", 64'(attr_o[3]), 64'h1a);

    // Two pads: lowest index goes first.
    wr(6, 5'b0_1_1_01);
    wr(1, 5'b1_0_1_11);
    clearStats();
    commit();
    runIdle("t3_timeout");
    chkVal("t3_busy_len", 64'(busyCnt), 64'd22);
    chkVal("t3_done_cnt", 64'(doneCnt), 64'd1);
    chkVal("t3_first_iso", 64'(firstIso), 64'h02);

    // Nothing dirty.
    clearStats();
    commit();
    runIdle("t4_timeout");
    chkVal("t4_busy_len", 64'(busyCnt), 64'd2);
    chkVal("t4_done_at", 64'(doneAt), 64'd2);

    // Mid-run writes: pad1 in its apply cycle, pad5 during its settle; commit while busy.
    wr(1, 5'b0_0_1_01);
    clearStats();
    commit();                            // cycle 1: scan
    for (int i = 0; i < 5; i++) tick();  // now showing cycle 6: apply
    wr(1, 5'b1_1_1_00);                  // sampled at the end of apply
    wr(5, 5'b0_1_0_11);                  // sampled during settle
    commit();
    runIdle("t5_timeout");
    chkVal("t5_busy_len", 64'(busyCnt), 64'd32);
    chkVal("t5_done_cnt", 64'(doneCnt), 64'd1);
    chkVal("t5_attr1", 64'(attr_o[1]), 64'h1c);
    chkVal("t5_attr5", 64'(attr_o[5]), 64'h0b);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        shadow_we_i   = 1'b1;
        shadow_idx_i  = 3'($urandom_range(0, NP - 1));
        shadow_attr_i = pad_attr_t'(5'($urandom_range(0, 31)));
      end
      if ($urandom_range(0, 15) == 0) commit_i = 1'b1;
      tick();
    end
    runIdle("rnd_timeout");
    commit();
    runIdle("rnd_flush_timeout");

    // Reset during settle of pad2. With 8 pads every 3-bit index addresses a real pad.
    wr(2, 5'b1_0_0_11);
    clearStats();
    commit();                            // cycle 1: scan
    for (int i = 0; i < 7; i++) tick();  // now showing cycle 8: settle
    chkVal("t6_pre_iso", 64'(iso_o), 64'h04);
    #2 rst_ni = 1'b0;
    #1;
    chkVal("t6_rst_iso", 64'(iso_o), 64'd0);
    chkVal("t6_rst_attr", 64'(attr_o), 64'd0);
    chkVal("t6_rst_busy", 64'(busy_o), 64'd0);
    modelReset();
    tick();
    rst_ni = 1'b1;
    tick();
    clearStats();
    commit();
    runIdle("t6_timeout");
    chkVal("t6_busy_len", 64'(busyCnt), 64'd2);
    chkVal("t6_done_cnt", 64'(doneCnt), 64'd1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
